// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the MEM-stage data memory controller.
// Size/extend encodings of req_op, FSM states, misalignment helper.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  localparam int unsigned OP_ZEXT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic misaligned(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (op[1:0])
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// SRAM-like data bus between the controller (master) and memory (slave).
// One address phase (req/addr_ok) followed by one data phase (data_ok).
interface dmem_ctrl_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_addr_ok,
    input  data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_addr_ok,
    output data_sram_data_ok,
    output data_sram_rdata
  );
endinterface

// File: rtl/dmem_align.sv
// Lane select, load extension, store strobes and store data replication.
// Offsets are truncated to size alignment, so misaligned ops hit aligned lanes.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // pick the addressed byte and halfword lanes of the read word
  always_comb begin
    b = rdata_i[7:0];
    unique case (off_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
    endcase
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // size decode: strobes, replicated store data, extended load data
  always_comb begin
    wen_o   = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    unique case (size_e'(size_i))
      SZ_B: begin
        wen_o   = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = zext_i ? {24'h0, b}
                         : {{24{b[7]}}, b};
      end
      SZ_H: begin
        wen_o   = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = zext_i ? {16'h0, h}
                         : {{16{h[15]}}, h};
      end
      default: begin
        wen_o   = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage load/store controller for an SRAM-like data bus.
// DMEM_MISALIGN_EXC_EN: misaligned requests skip the bus and flag misalign_exc.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  dmem_ctrl_if.master bus,
  output logic        stallreq,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_exc
);

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_q;
  logic        cap;
  logic        lat;
  logic        mis_q;
  logic [3:0]  a_wen;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;

  dmem_align u_align (
    .size_i  (op_q[1:0]),
    .zext_i  (op_q[OP_ZEXT]),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus.data_sram_rdata),
    .wen_o   (a_wen),
    .wdata_o (a_wdata),
    .rdata_o (a_rdata)
  );

  // next state, stall and capture/latch strobes
  always_comb begin
    state_d  = state_q;
    stallreq = 1'b0;
    cap      = 1'b0;
    lat      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          stallreq = 1'b1;
          cap      = 1'b1;
`ifdef DMEM_MISALIGN_EXC_EN
          if (misaligned(req_op, req_addr[1:0]))
            state_d = DONE;
          else
            state_d = ADDR;
`else
          state_d  = ADDR;
`endif
        end
      end
      ADDR: begin
        stallreq = 1'b1;
        if (bus.data_sram_addr_ok) begin
          if (bus.data_sram_data_ok) begin
            lat     = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        stallreq = 1'b1;
        if (bus.data_sram_data_ok) begin
          lat     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // request capture and load result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ld_q    <= 32'h0;
    end else begin
      if (cap) begin
        we_q    <= req_we;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (lat) ld_q <= a_rdata;
    end
  end

`ifdef DMEM_MISALIGN_EXC_EN
  // misalignment is judged on the incoming request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      mis_q <= 1'b0;
    else if (cap) mis_q <= misaligned(req_op, req_addr[1:0]);
  end
`else
  assign mis_q = 1'b0;
`endif

  assign bus.data_sram_req   = (state_q == ADDR);
  assign bus.data_sram_wr    = (state_q == ADDR) & we_q;
  assign bus.data_sram_wen   = we_q ? a_wen : 4'b0000;
  assign bus.data_sram_addr  = {addr_q[31:2], 2'b00};
  assign bus.data_sram_wdata = we_q ? a_wdata : 32'h0;

  assign load_valid   = (state_q == DONE) & ~we_q & ~mis_q;
  assign load_data    = ld_q;
  assign misalign_exc = (state_q == DONE) & mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed loads/stores, bus delays,
// reset mid-transaction, back-to-back held request.
module tb_dmem_ctrl;

  typedef struct {
    logic        wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        lv;
    logic        exc;
    logic [31:0] data;
  } ld_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stallreq;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign_exc;

  int checks = 0;
  int errors = 0;

  bus_t bus_q[$];
  ld_t  ld_q[$];

  logic [31:0] s_rdata = 32'h0;
  int          s_adly = 0;
  int          s_ddly = 0;

  dmem_ctrl_if bus();

  dmem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .bus          (bus),
    .stallreq     (stallreq),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory slave: addr_ok after s_adly req cycles, data_ok s_ddly later
  initial begin
    int  acnt;
    int  dcnt;
    bit  pend;
    acnt = 0;
    dcnt = 0;
    pend = 0;
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.data_sram_addr_ok = 1'b0;
      bus.data_sram_data_ok = 1'b0;
      if (bus.data_sram_req) begin
        if (acnt == s_adly) begin
          bus.data_sram_addr_ok = 1'b1;
          acnt = 0;
          if (s_ddly == 0) begin
            bus.data_sram_data_ok = 1'b1;
            bus.data_sram_rdata   = s_rdata;
          end else begin
            pend = 1;
            dcnt = 0;
          end
        end else begin
          acnt++;
        end
      end else if (pend) begin
        dcnt++;
        if (dcnt == s_ddly) begin
          bus.data_sram_data_ok = 1'b1;
          bus.data_sram_rdata   = s_rdata;
          pend = 0;
        end
      end
    end
  end

  // monitor: bus acceptances and load/exception results vs scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_sram_req && bus.data_sram_addr_ok) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got addr %0h expected none",
                   bus.data_sram_addr);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_fields",
              {bus.data_sram_wr, bus.data_sram_wen,
               bus.data_sram_addr, bus.data_sram_wdata},
              {e.wr, e.wen, e.addr, e.wdata});
        end
      end
      if (load_valid || misalign_exc) begin
        if (ld_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ld_unexpected: got lv=%0b exc=%0b expected none",
                   load_valid, misalign_exc);
        end else begin
          ld_t e;
          e = ld_q.pop_front();
          chk("ld_flags", {load_valid, misalign_exc}, {e.lv, e.exc});
          if (e.lv) chk("ld_data", load_data, e.data);
        end
      end
    end
  end

  task automatic issue(
    input bit          we,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          ad,
    input int          dd,
    input bit          bus_en,
    input bus_t        eb,
    input bit          ld_en,
    input ld_t         el,
    input int          exp_stall,
    input int          exp_req,
    input bit          hold
  );
    int st;
    int rq;
    bit done;
    @(posedge clk);
    #1;
    if (bus_en) bus_q.push_back(eb);
    if (ld_en)  ld_q.push_back(el);
    s_rdata   = rd;
    s_adly    = ad;
    s_ddly    = dd;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    st = 0;
    rq = 0;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.data_sram_req) rq++;
      if (stallreq) st++;
      else begin
        done = 1;
        break;
      end
    end
    chk("done_reached", done, 1'b1);
    chk("stall_cycles", st, exp_stall);
    chk("req_cycles", rq, exp_req);
    if (!hold) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus_t nb;
    ld_t  nl;
    nb = '{1'b0, 4'h0, 32'h0, 32'h0};
    nl = '{1'b0, 1'b0, 32'h0};

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {stallreq, load_valid, load_data, misalign_exc,
         bus.data_sram_req, bus.data_sram_wr, bus.data_sram_wen,
         bus.data_sram_addr, bus.data_sram_wdata},
        '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LB 0x103
    issue(0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 1,
          1, '{1'b0, 4'b0000, 32'h100, 32'h0},
          1, '{1'b1, 1'b0, 32'hFFFF_FF80}, 3, 1, 0);
    // SH 0x202
    issue(1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 0, 1,
          1, '{1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF},
          0, nl, 3, 1, 0);
    // LW with slow address and data phases
    issue(0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, 3, 2,
          1, '{1'b0, 4'b0000, 32'h300, 32'h0},
          1, '{1'b1, 1'b0, 32'h1234_5678}, 7, 4, 0);
    // LBU 0x101, addr_ok and data_ok together
    issue(0, 3'b100, 32'h101, 32'h0, 32'h0000_9A00, 0, 0,
          1, '{1'b0, 4'b0000, 32'h100, 32'h0},
          1, '{1'b1, 1'b0, 32'h0000_009A}, 2, 1, 0);
    // LH 0x102, upper half sign-extended
    issue(0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 1, 0,
          1, '{1'b0, 4'b0000, 32'h100, 32'h0},
          1, '{1'b1, 1'b0, 32'hFFFF_8001}, 3, 2, 0);
    // SB 0x001
    issue(1, 3'b000, 32'h001, 32'h0000_00A5, 32'h0, 0, 1,
          1, '{1'b1, 4'b0010, 32'h0, 32'hA5A5_A5A5},
          0, nl, 3, 1, 0);
    // SW 0x044
    issue(1, 3'b010, 32'h044, 32'hDEAD_BEEF, 32'h0, 0, 1,
          1, '{1'b1, 4'b1111, 32'h44, 32'hDEAD_BEEF},
          0, nl, 3, 1, 0);
    // reserved size behaves as word
    issue(0, 3'b011, 32'h600, 32'h0, 32'h55AA_33CC, 0, 1,
          1, '{1'b0, 4'b0000, 32'h600, 32'h0},
          1, '{1'b1, 1'b0, 32'h55AA_33CC}, 3, 1, 0);
`ifdef DMEM_MISALIGN_EXC_EN
    // LHU 0x101 misaligned: no bus access, exception in DONE
    issue(0, 3'b101, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 1,
          0, nb,
          1, '{1'b0, 1'b1, 32'h0}, 1, 0, 0);
`else
    // LHU 0x101 misaligned: truncated to 0x100, lanes [15:0]
    issue(0, 3'b101, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 1,
          1, '{1'b0, 4'b0000, 32'h100, 32'h0},
          1, '{1'b1, 1'b0, 32'h0000_F00D}, 3, 1, 0);
`endif
    // LW held through DONE, then SB next cycle: exactly two transactions
    issue(0, 3'b010, 32'h500, 32'h0, 32'h0BAD_F00D, 0, 1,
          1, '{1'b0, 4'b0000, 32'h500, 32'h0},
          1, '{1'b1, 1'b0, 32'h0BAD_F00D}, 3, 1, 1);
    issue(1, 3'b000, 32'h503, 32'h0000_007F, 32'h0, 0, 1,
          1, '{1'b1, 4'b1000, 32'h500, 32'h7F7F_7F7F},
          0, nl, 3, 1, 0);

    // reset in DATA; the late data_ok must be ignored
    @(posedge clk);
    #1;
    bus_q.push_back('{1'b0, 4'b0000, 32'h700, 32'h0});
    s_rdata   = 32'hDEAD_0001;
    s_adly    = 0;
    s_ddly    = 3;
    req_we    = 1'b0;
    req_op    = 3'b010;
    req_addr  = 32'h700;
    req_wdata = 32'h0;
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_data_stall", {stallreq, bus.data_sram_req}, 2'b10);
    rst = 1'b1;
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet",
          {load_valid, stallreq, misalign_exc,
           bus.data_sram_req, load_data},
          {1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    end

    repeat (3) @(negedge clk);
    chk("bus_queue_empty", bus_q.size(), 0);
    chk("ld_queue_empty", ld_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 req_valid  in  1  MEM-stage load/store request present; held stable while stallreq=1.
REQ-004 req_we  in  1  1=store, 0=load.
REQ-005 req_op  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 reserved=word); [2] 1=zero-extend load.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data, right-aligned.
REQ-008 data_sram_req  out  1  SRAM-like bus request.
REQ-009 data_sram_wr  out  1  bus write flag.
REQ-010 data_sram_wen  out  4  byte write strobes.
REQ-011 data_sram_addr  out  32  word-aligned bus address.
REQ-012 data_sram_wdata  out  32  lane-replicated store data.
REQ-013 data_sram_addr_ok  in  1  bus accepted address this cycle.
REQ-014 data_sram_data_ok  in  1  bus returned data / write completion this cycle.
REQ-015 data_sram_rdata  in  32  bus read data, valid with data_ok.
REQ-016 stallreq  out  1  hold EX/MEM pipeline register (feeds stall bus).
REQ-017 load_valid  out  1  load_data valid this cycle.
REQ-018 load_data  out  32  extended load result.
REQ-019 misalign_exc  out  1  misaligned access flag.

Function
REQ-020 FSM states SHALL be IDLE, ADDR, DATA, DONE.
REQ-021 IDLE: on req_valid, capture we/op/addr/wdata, assert stallreq combinationally that cycle, next state ADDR.
REQ-022 ADDR: data_sram_req=1 with captured fields; on addr_ok go DATA, else stay ADDR; stallreq=1.
REQ-023 DATA: data_sram_req=0; on data_ok latch extended rdata and go DONE; stallreq=1.
REQ-024 addr_ok and data_ok in the same ADDR cycle SHALL go directly to DONE.
REQ-025 DONE: stallreq=0, load_valid=1 for loads only, one cycle, then IDLE; req_valid in DONE SHALL be ignored (same held instruction).
REQ-026 data_ok in IDLE or ADDR-without-addr_ok SHALL be ignored.
REQ-027 Loads: select byte addr[1:0] / half addr[1]; sign-extend unless req_op[2]=1; word passes through.
REQ-028 Stores: wen = 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half), 1111 (word); wdata = byte x4 / half x2 / word.
REQ-029 data_sram_addr = {addr[31:2],2'b00}; data_sram_wen=0 for loads.
REQ-030 Misalignment: half with addr[0]=1, word with addr[1:0]!=0.
REQ-031 Maximum one outstanding transaction; minimum latency IDLE->DONE = 2 cycles.

Reset
REQ-032 rst SHALL force IDLE immediately, abandoning any in-flight transaction.
REQ-033 Reset values: all outputs 0, captured request registers 0.
REQ-034 Late data_ok after reset SHALL be discarded (IDLE ignores it).

Configuration
REQ-035 With DMEM_MISALIGN_EXC_EN defined: misaligned request goes IDLE->DONE, no bus request, misalign_exc=1 and load_valid=0 in DONE, stallreq asserted only in the IDLE cycle.
REQ-036 Without DMEM_MISALIGN_EXC_EN: misalign_exc tied 0; misaligned addresses truncated to size alignment and accessed normally.

Structure
REQ-037 Size/extend encodings of req_op and FSM state encodings SHALL live in defines.vh.
REQ-038 Lane select/extend/strobe logic SHALL be a combinational sub-module dmem_align.

Verification
REQ-039 LB addr 0x103, rdata 0x80FF_0000, addr_ok/data_ok next cycles -> load_data 0xFFFF_FF80, load_valid one cycle, stallreq 3 cycles.
REQ-040 SH addr 0x202, wdata 0x0000_BEEF -> wen 1100, wdata 0xBEEF_BEEF, addr 0x200, load_valid 0.
REQ-041 LW with addr_ok delayed 3 cycles, data_ok delayed 2 more -> data_sram_req held 4 cycles, stallreq high until DONE, result exact.
REQ-042 rst pulse in DATA, then data_ok -> state IDLE, load_valid stays 0, no capture.
REQ-043 LHU addr 0x101 with DMEM_MISALIGN_EXC_EN -> no data_sram_req, misalign_exc=1 next cycle; without macro -> access at 0x100, lanes [15:0].
REQ-044 req_valid held through DONE then new request next cycle -> exactly two bus transactions, no duplicate.
